// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - debounced receive-side decoder for a multiplexed active-low 7-segment bus
//
// Purpose:
//   Samples {seg, dpt, dig_sel} whenever seg_vld is high. Each digit slot
//   keeps its own candidate pattern and a saturating match counter. A slot
//   commits when the counter reaches exactly STABLE_CNT. On commit the
//   candidate is decoded back to a digit value.
//
// Parameters:
//   STABLE_CNT  consecutive identical samples for a slot to commit (1..7)
//
// Configuration macro:
//   SEG7_DECODE_HEX_EN  when defined, the A b C d E F glyphs also decode legally
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   seg_vld    sample strobe for seg/dpt/dig_sel
//   seg[6:0]   segment pattern g..a, 0 = lit
//   dpt        decimal point, 0 = lit
//   dig_sel    slot index 0..3
//   dig_val    committed values, slot k at [4k+3:4k]
//   dig_dp     committed decimal points, 1 = lit
//   dig_err    slot committed an illegal pattern
//   dig_blank  slot committed the all-dark pattern
//   upd        one-cycle commit pulse
//   upd_idx    slot of the most recent commit
module seg7_scan_decoder #(
    parameter int STABLE_CNT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_vld,
    input  logic [6:0]  seg,
    input  logic        dpt,
    input  logic [1:0]  dig_sel,
    output logic [15:0] dig_val,
    output logic [3:0]  dig_dp,
    output logic [3:0]  dig_err,
    output logic [3:0]  dig_blank,
    output logic        upd,
    output logic [1:0]  upd_idx
);

    localparam logic [2:0] STABLE = 3'(STABLE_CNT);

    // Returns {err, blank, value}.
    function automatic logic [5:0] decode(input logic [6:0] pat);
        logic [5:0] r;
        case (pat)
            7'b1000000: r = {2'b00, 4'h0};
            7'b1111001: r = {2'b00, 4'h1};
            7'b0100100: r = {2'b00, 4'h2};
            7'b0110000: r = {2'b00, 4'h3};
            7'b0011001: r = {2'b00, 4'h4};
            7'b0010010: r = {2'b00, 4'h5};
            7'b0000010: r = {2'b00, 4'h6};
            7'b1111000: r = {2'b00, 4'h7};
            7'b0000000: r = {2'b00, 4'h8};
            7'b0010000: r = {2'b00, 4'h9};
`ifdef SEG7_DECODE_HEX_EN
            7'b0001000: r = {2'b00, 4'hA};
            7'b0000011: r = {2'b00, 4'hB};
            7'b1000110: r = {2'b00, 4'hC};
            7'b0100001: r = {2'b00, 4'hD};
            7'b0000110: r = {2'b00, 4'hE};
            7'b0001110: r = {2'b00, 4'hF};
`endif
            7'b1111111: r = {2'b01, 4'h0};
            default:    r = {2'b10, 4'h0};
        endcase
        return r;
    endfunction

    // Stage 1 sample register
    logic        s1_vld_q, s1_vld_d;
    logic [6:0]  s1_seg_q, s1_seg_d;
    logic        s1_dpt_q, s1_dpt_d;
    logic [1:0]  s1_sel_q, s1_sel_d;

    // Stage 2 per-slot debounce state
    logic [7:0]  cand_q [4];
    logic [7:0]  cand_d [4];
    logic [2:0]  cnt_q  [4];
    logic [2:0]  cnt_d  [4];

    // Committed outputs
    logic [15:0] dig_val_q, dig_val_d;
    logic [3:0]  dig_dp_q, dig_dp_d;
    logic [3:0]  dig_err_q, dig_err_d;
    logic [3:0]  dig_blank_q, dig_blank_d;
    logic        upd_q, upd_d;
    logic [1:0]  upd_idx_q, upd_idx_d;

    // Combinational helpers
    logic [7:0]  sample;
    logic [2:0]  new_cnt;
    logic        replaced;
    logic [5:0]  dec;

    always_comb begin
        s1_vld_d    = seg_vld;
        s1_seg_d    = seg_vld ? seg : s1_seg_q;
        s1_dpt_d    = seg_vld ? dpt : s1_dpt_q;
        s1_sel_d    = seg_vld ? dig_sel : s1_sel_q;

        cand_d      = cand_q;
        cnt_d       = cnt_q;
        dig_val_d   = dig_val_q;
        dig_dp_d    = dig_dp_q;
        dig_err_d   = dig_err_q;
        dig_blank_d = dig_blank_q;
        upd_d       = 1'b0;
        upd_idx_d   = upd_idx_q;

        sample      = {s1_seg_q, s1_dpt_q};
        new_cnt     = 3'd0;
        replaced    = 1'b0;
        dec         = decode(s1_seg_q);

        if (s1_vld_q) begin
            if (sample == cand_q[s1_sel_q]) begin
                new_cnt = (cnt_q[s1_sel_q] == 3'd7) ? 3'd7 : cnt_q[s1_sel_q] + 3'd1;
            end else begin
                new_cnt  = 3'd1;
                replaced = 1'b1;
            end
            cand_d[s1_sel_q] = sample;
            cnt_d[s1_sel_q]  = new_cnt;

            // Commit only on the transition into STABLE; a saturated counter
            // sitting at 7 never re-commits even when STABLE_CNT is 7.
            if (new_cnt == STABLE && (replaced || new_cnt != cnt_q[s1_sel_q])) begin
                dig_val_d[{s1_sel_q, 2'b00} +: 4] = dec[3:0];
                dig_dp_d[s1_sel_q]    = ~s1_dpt_q;
                dig_err_d[s1_sel_q]   = dec[5];
                dig_blank_d[s1_sel_q] = dec[4];
                upd_d                 = 1'b1;
                upd_idx_d             = s1_sel_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_seg_q    <= 7'h7F;
            s1_dpt_q    <= 1'b1;
            s1_sel_q    <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                cand_q[k] <= 8'hFF;
                cnt_q[k]  <= 3'd0;
            end
            dig_val_q   <= 16'h0000;
            dig_dp_q    <= 4'h0;
            dig_err_q   <= 4'h0;
            dig_blank_q <= 4'hF;
            upd_q       <= 1'b0;
            upd_idx_q   <= 2'd0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_seg_q    <= s1_seg_d;
            s1_dpt_q    <= s1_dpt_d;
            s1_sel_q    <= s1_sel_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            dig_val_q   <= dig_val_d;
            dig_dp_q    <= dig_dp_d;
            dig_err_q   <= dig_err_d;
            dig_blank_q <= dig_blank_d;
            upd_q       <= upd_d;
            upd_idx_q   <= upd_idx_d;
        end
    end

    assign dig_val   = dig_val_q;
    assign dig_dp    = dig_dp_q;
    assign dig_err   = dig_err_q;
    assign dig_blank = dig_blank_q;
    assign upd       = upd_q;
    assign upd_idx   = upd_idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        seg_vld;
    logic [6:0]  seg;
    logic        dpt;
    logic [1:0]  dig_sel;
    logic [15:0] dig_val;
    logic [3:0]  dig_dp;
    logic [3:0]  dig_err;
    logic [3:0]  dig_blank;
    logic        upd;
    logic [1:0]  upd_idx;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] val;
        logic       dp;
        logic       err;
        logic       blank;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    seg7_scan_decoder #(.STABLE_CNT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_vld   (seg_vld),
        .seg       (seg),
        .dpt       (dpt),
        .dig_sel   (dig_sel),
        .dig_val   (dig_val),
        .dig_dp    (dig_dp),
        .dig_err   (dig_err),
        .dig_blank (dig_blank),
        .upd       (upd),
        .upd_idx   (upd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every upd pulse pops one expected commit and checks that slot.
    always @(negedge clk) begin
        if (rst_n && upd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_upd actual=idx%0d required=none", upd_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("upd_idx", 32'(upd_idx), 32'(e.idx));
                check("dig_val_slot", 32'(dig_val[{e.idx, 2'b00} +: 4]), 32'(e.val));
                check("dig_dp_slot", 32'(dig_dp[e.idx]), 32'(e.dp));
                check("dig_err_slot", 32'(dig_err[e.idx]), 32'(e.err));
                check("dig_blank_slot", 32'(dig_blank[e.idx]), 32'(e.blank));
            end
        end
    end

    task automatic expect_commit(input logic [1:0] idx, input logic [3:0] val,
                                 input logic dp, input logic err, input logic blank);
        exp_t e;
        e.idx = idx; e.val = val; e.dp = dp; e.err = err; e.blank = blank;
        exp_q.push_back(e);
    endtask

    task automatic strobe(input logic [1:0] sel, input logic [6:0] pat, input logic dp);
        seg_vld = 1'b1;
        dig_sel = sel;
        seg     = pat;
        dpt     = dp;
        @(posedge clk);
        #1;
        seg_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_upd actual=%0d pending required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        seg_vld = 1'b0;
        seg     = 7'h7F;
        dpt     = 1'b1;
        dig_sel = 2'd0;

        // Reset state
        #12;
        check("rst_dig_val", 32'(dig_val), 32'h0000);
        check("rst_dig_dp", 32'(dig_dp), 32'h0);
        check("rst_dig_err", 32'(dig_err), 32'h0);
        check("rst_dig_blank", 32'(dig_blank), 32'hF);
        check("rst_upd", 32'(upd), 32'h0);
        check("rst_upd_idx", 32'(upd_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Slot 0 value 3, dp dark; upd two clocks after the first strobe
        expect_commit(2'd0, 4'h3, 1'b0, 1'b0, 1'b0);
        strobe(2'd0, 7'b0110000, 1'b1);
        strobe(2'd0, 7'b0110000, 1'b1);
        check("t1_upd_early", 32'(upd), 32'h0);
        @(posedge clk); #1;
        check("t1_upd_pulse", 32'(upd), 32'h1);
        check("t1_upd_idx", 32'(upd_idx), 32'h0);
        @(posedge clk); #1;
        check("t1_upd_single", 32'(upd), 32'h0);
        drain("t1");

        // Reset mid-stream with a sample in flight
        strobe(2'd0, 7'b1111001, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dig_val", 32'(dig_val), 32'h0000);
        check("mid_rst_dig_blank", 32'(dig_blank), 32'hF);
        check("mid_rst_dig_dp", 32'(dig_dp), 32'h0);
        check("mid_rst_upd", 32'(upd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        strobe(2'd0, 7'b1111001, 1'b1);
        idle(3);
        expect_commit(2'd0, 4'h1, 1'b0, 1'b0, 1'b0);
        strobe(2'd0, 7'b1111001, 1'b1);
        drain("mid_rst");

        // Interleaved scan, back-to-back commits on the second round
        strobe(2'd0, 7'b1000000, 1'b1);
        strobe(2'd1, 7'b1000000, 1'b1);
        strobe(2'd2, 7'b1000000, 1'b1);
        strobe(2'd3, 7'b0100100, 1'b1);
        expect_commit(2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_commit(2'd1, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_commit(2'd2, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_commit(2'd3, 4'h2, 1'b0, 1'b0, 1'b0);
        strobe(2'd0, 7'b1000000, 1'b1);
        strobe(2'd1, 7'b1000000, 1'b1);
        strobe(2'd2, 7'b1000000, 1'b1);
        strobe(2'd3, 7'b0100100, 1'b1);
        drain("scan");
        check("scan_dig_val", 32'(dig_val), 32'h2000);
        check("scan_dig_blank", 32'(dig_blank), 32'h0);
        check("scan_dig_err", 32'(dig_err), 32'h0);

        // Glitch on slot 1: mismatches restart the run
        strobe(2'd1, 7'b1111001, 1'b1);
        strobe(2'd1, 7'b0100100, 1'b1);
        strobe(2'd1, 7'b1111001, 1'b1);
        expect_commit(2'd1, 4'h1, 1'b0, 1'b0, 1'b0);
        strobe(2'd1, 7'b1111001, 1'b1);
        drain("glitch");
        check("glitch_dig_val", 32'(dig_val), 32'h2010);

        // Decimal point change alone on slot 0 restarts and recommits
        strobe(2'd0, 7'b1000000, 1'b0);
        expect_commit(2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        strobe(2'd0, 7'b1000000, 1'b0);
        drain("dpt");
        check("dpt_dig_dp", 32'(dig_dp), 32'h1);

        // Illegal-or-hex pattern then blank on slot 2
        strobe(2'd2, 7'b0000110, 1'b0);
`ifdef SEG7_DECODE_HEX_EN
        expect_commit(2'd2, 4'hE, 1'b1, 1'b0, 1'b0);
`else
        expect_commit(2'd2, 4'h0, 1'b1, 1'b1, 1'b0);
`endif
        strobe(2'd2, 7'b0000110, 1'b0);
        drain("illegal");
        strobe(2'd2, 7'b1111111, 1'b1);
        expect_commit(2'd2, 4'h0, 1'b0, 1'b0, 1'b1);
        strobe(2'd2, 7'b1111111, 1'b1);
        drain("blank");
        check("blank_dig_blank", 32'(dig_blank), 32'h4);
        check("blank_dig_err", 32'(dig_err), 32'h0);

        // Saturation: 20 identical strobes on slot 3 give one commit
        expect_commit(2'd3, 4'h9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) strobe(2'd3, 7'b0010000, 1'b1);
        drain("sat");
        check("sat_dig_val", 32'(dig_val), 32'h9010);

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
